traffic_phase_ctrl: RTL and testbench

//  Parametrised density-based traffic sequencer for NUM_SIDES approaches.
//  - Runs a GREEN -> YELLOW -> ALLRED cycle for one side at a time.
//  - Green time is sized from that side's density value.
//  - Skips sides with no request; cuts green short when the active side empties.
//  - Honours an emergency pre-emption request.
//  - Replaces the fixed 4-side sequencer and its external timer; Tick comes from the shared prescaler.

---
 rtl/traffic_phase_if.sv | 31 +++
 rtl/traffic_phase_ctrl.sv | 142 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_if.sv
// Bundles the sequencer's control inputs and signal-status outputs.
// The controller uses the slave modport; the supervising logic uses master.
interface traffic_phase_if #(
  parameter int NUM_SIDES = 4,
  parameter int DENS_W    = 4,
  parameter int GREEN_MAX = 40
);
  localparam int SIDE_W = (NUM_SIDES > 2) ? $clog2(NUM_SIDES) : 1;
  localparam int TMR_W  = $clog2(GREEN_MAX + 1);

  logic                        Tick;
  logic [NUM_SIDES-1:0]        Req;
  logic [NUM_SIDES*DENS_W-1:0] Density;
  logic                        Emerg_Req;
  logic [SIDE_W-1:0]           Emerg_Side;
  logic [SIDE_W-1:0]           Side;
  logic [1:0]                  Phase;
  logic [TMR_W-1:0]            Remain;
  logic                        Side_Change;
  logic                        Emerg_Active;

  modport master (
    output Tick, Req, Density, Emerg_Req, Emerg_Side,
    input  Side, Phase, Remain, Side_Change, Emerg_Active
  );

  modport slave (
    input  Tick, Req, Density, Emerg_Req, Emerg_Side,
    output Side, Phase, Remain, Side_Change, Emerg_Active
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Density-based traffic sequencer: GREEN -> YELLOW -> ALLRED per side, with
// request skipping, gap-out and emergency pre-emption. All outputs registered.
module traffic_phase_ctrl #(
  parameter int NUM_SIDES  = 4,
  parameter int DENS_W     = 4,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_UNIT = 2,
  parameter int GREEN_MAX  = 40,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1
) (
  input  logic Clk,
  input  logic Reset,
  traffic_phase_if.slave bus
);
  localparam int SIDE_W = (NUM_SIDES > 2) ? $clog2(NUM_SIDES) : 1;
  localparam int TMR_W  = $clog2(GREEN_MAX + 1);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [TMR_W-1:0]  remain_q, remain_d;
  logic [TMR_W-1:0]  elapsed_q, elapsed_d;
  logic              side_change_q, side_change_d;
  logic              emerg_active_q, emerg_active_d;

  logic              emerg_valid;
  logic              hold;
  logic              found;
  logic [SIDE_W-1:0] cand;
  logic [SIDE_W-1:0] next_side;
  logic [DENS_W-1:0] dens [NUM_SIDES];

  // Wide intermediate so a large density can never wrap before clamping.
  function automatic logic [TMR_W-1:0] green_load(input logic [DENS_W-1:0] d);
    logic [63:0] wide;
    wide = 64'(GREEN_MIN) + 64'(GREEN_UNIT) * 64'(d);
    if (wide > 64'(GREEN_MAX)) return TMR_W'(GREEN_MAX);
    return wide[TMR_W-1:0];
  endfunction

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    if (v >= TMR_W'(GREEN_MAX)) return TMR_W'(GREEN_MAX);
    return v + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SIDES; i++) dens[i] = bus.Density[i*DENS_W +: DENS_W];
  end

  assign emerg_valid = bus.Emerg_Req && (32'(bus.Emerg_Side) < NUM_SIDES);
  assign hold        = emerg_valid && (bus.Emerg_Side == side_q);

  // Rotating search starting after the current side; the current side comes last.
  always_comb begin
    next_side = SIDE_W'((32'(side_q) + 1) % NUM_SIDES);
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_SIDES; i++) begin
      cand = SIDE_W'((32'(side_q) + 32'(i)) % NUM_SIDES);
      if (!found && bus.Req[cand]) begin
        next_side = cand;
        found     = 1'b1;
      end
    end
    if (emerg_valid) next_side = bus.Emerg_Side;
  end

  always_comb begin
    phase_d       = phase_q;
    side_d        = side_q;
    remain_d      = remain_q;
    elapsed_d     = elapsed_q;
    side_change_d = 1'b0;
    if (bus.Tick) begin
      unique case (phase_q)
        GREEN: begin
          if (!hold) begin
            if (remain_q == TMR_W'(1) || emerg_valid ||
                (!bus.Req[side_q] && elapsed_q >= TMR_W'(GREEN_MIN))) begin
              phase_d  = YELLOW;
              remain_d = TMR_W'(YELLOW_T);
            end else begin
              remain_d  = remain_q - 1'b1;
              elapsed_d = sat_inc(elapsed_q);
            end
          end
        end
        YELLOW: begin
          if (remain_q == TMR_W'(1)) begin
            phase_d  = ALLRED;
            remain_d = TMR_W'(ALLRED_T);
          end else begin
            remain_d = remain_q - 1'b1;
          end
        end
        ALLRED: begin
          if (remain_q == TMR_W'(1)) begin
            phase_d       = GREEN;
            side_d        = next_side;
            remain_d      = green_load(dens[next_side]);
            elapsed_d     = '0;
            side_change_d = 1'b1;
          end else begin
            remain_d = remain_q - 1'b1;
          end
        end
        default: phase_d = GREEN;
      endcase
    end
    emerg_active_d = (phase_d == GREEN) && emerg_valid && (bus.Emerg_Side == side_d);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      phase_q        <= GREEN;
      side_q         <= '0;
      remain_q       <= TMR_W'(GREEN_MIN);
      elapsed_q      <= '0;
      side_change_q  <= 1'b0;
      emerg_active_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      side_q         <= side_d;
      remain_q       <= remain_d;
      elapsed_q      <= elapsed_d;
      side_change_q  <= side_change_d;
      emerg_active_q <= emerg_active_d;
    end
  end

  assign bus.Side         = side_q;
  assign bus.Phase        = phase_q;
  assign bus.Remain       = remain_q;
  assign bus.Side_Change  = side_change_q;
  assign bus.Emerg_Active = emerg_active_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked against a
// tick-level behavioural model of the sequencing rules.
module tb_traffic_phase_ctrl;
  localparam int NS    = 4;
  localparam int DW    = 4;
  localparam int GMIN  = 4;
  localparam int GUNIT = 2;
  localparam int GMAX  = 20;
  localparam int YT    = 2;
  localparam int AT    = 1;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_if #(.NUM_SIDES(NS), .DENS_W(DW), .GREEN_MAX(GMAX)) bus ();

  traffic_phase_ctrl #(
    .NUM_SIDES(NS), .DENS_W(DW), .GREEN_MIN(GMIN), .GREEN_UNIT(GUNIT),
    .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(AT)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Model state: phase 0=green 1=yellow 2=allred
  int m_side, m_phase, m_remain, m_elapsed;
  int m_sc, m_ea;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_side = 0; m_phase = 0; m_remain = GMIN; m_elapsed = 0; m_sc = 0; m_ea = 0;
  endtask

  function automatic int load_for(input int s);
    int d, v;
    d = int'((bus.Density >> (s * DW)) & 16'hF);
    v = GMIN + GUNIT * d;
    return (v > GMAX) ? GMAX : v;
  endfunction

  function automatic bit req_bit(input int s);
    return ((bus.Req >> s) & 4'd1) != 4'd0;
  endfunction

  function automatic int pick_next(input bit ev);
    if (ev) return int'(bus.Emerg_Side);
    for (int k = 1; k <= NS; k++)
      if (req_bit((m_side + k) % NS)) return (m_side + k) % NS;
    return (m_side + 1) % NS;
  endfunction

  task automatic model_advance();
    bit ev;
    int nxt;
    ev   = bus.Emerg_Req && (int'(bus.Emerg_Side) < NS);
    m_sc = 0;
    if (bus.Tick) begin
      if (m_phase == 0 && ev && int'(bus.Emerg_Side) == m_side) begin
        // emergency green: everything frozen
      end else if (m_remain == 1 ||
                   (m_phase == 0 && (ev || (!req_bit(m_side) && m_elapsed >= GMIN)))) begin
        case (m_phase)
          0: begin m_phase = 1; m_remain = YT; end
          1: begin m_phase = 2; m_remain = AT; end
          default: begin
            nxt       = pick_next(ev);
            m_side    = nxt;
            m_phase   = 0;
            m_remain  = load_for(nxt);
            m_elapsed = 0;
            m_sc      = 1;
          end
        endcase
      end else begin
        m_remain--;
        if (m_phase == 0 && m_elapsed < GMAX) m_elapsed++;
      end
    end
    m_ea = (m_phase == 0 && ev && int'(bus.Emerg_Side) == m_side) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_side"},   32'(bus.Side),         32'(m_side));
    check({tag, "_phase"},  32'(bus.Phase),        32'(m_phase));
    check({tag, "_remain"}, 32'(bus.Remain),       32'(m_remain));
    check({tag, "_sc"},     32'(bus.Side_Change),  32'(m_sc));
    check({tag, "_ea"},     32'(bus.Emerg_Active), 32'(m_ea));
  endtask

  task automatic step();
    model_advance();
    @(posedge Clk);
    #1;
    check_all("step");
  endtask

  task automatic wait_sc(input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (bus.Side_Change === 1'b1) return;
    end
    check("sc_timeout", 32'(bus.Side_Change), 32'd1);
  endtask

  task automatic wait_phase(input int p, input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (int'(bus.Phase) == p) return;
    end
    check("phase_timeout", 32'(bus.Phase), 32'(p));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge Clk);
    #1;
    check_all("rst_hold");
    Reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    Reset          = 1'b1;
    bus.Tick       = 1'b1;
    bus.Req        = 4'h0;
    bus.Density    = 16'h0;
    bus.Emerg_Req  = 1'b0;
    bus.Emerg_Side = 2'd0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    check("rst_side",   32'(bus.Side),   32'd0);
    check("rst_phase",  32'(bus.Phase),  32'd0);
    check("rst_remain", 32'(bus.Remain), 32'd4);
    check("rst_sc",     32'(bus.Side_Change), 32'd0);
    Reset = 1'b0;

    // 4 green + 2 yellow + 1 allred, then side 1 loads 4+2*3
    bus.Req     = 4'hF;
    bus.Density = 16'h0030;
    repeat (6) step();
    check("s1_allred", 32'(bus.Phase), 32'd2);
    step();
    check("s1_side",   32'(bus.Side),   32'd1);
    check("s2_remain", 32'(bus.Remain), 32'd10);
    check("s2_sc",     32'(bus.Side_Change), 32'd1);
    step();
    check("s2_sc_pulse", 32'(bus.Side_Change), 32'd0);

    // Only side 1 requesting: it is picked again, density 15 clamps to 20
    bus.Req     = 4'b0010;
    bus.Density = 16'h00F0;
    wait_sc(40);
    check("s2_same_side", 32'(bus.Side),   32'd1);
    check("s2_sat",       32'(bus.Remain), 32'd20);

    do_reset();
    bus.Req     = 4'b1001;
    bus.Density = 16'h0000;
    wait_sc(20);
    check("s3_skip", 32'(bus.Side), 32'd3);
    bus.Req = 4'h0;
    wait_sc(20);
    check("s3_norq", 32'(bus.Side), 32'd0);

    // Gap-out on side 1 after request drops at elapsed=1
    bus.Req     = 4'b0010;
    bus.Density = 16'h0050;
    wait_sc(20);
    check("s4_side",   32'(bus.Side),   32'd1);
    check("s4_remain", 32'(bus.Remain), 32'd14);
    step();
    bus.Req = 4'h0;
    repeat (3) step();
    check("s4_still_green", 32'(bus.Phase), 32'd0);
    step();
    check("s4_gapout", 32'(bus.Phase),  32'd1);
    check("s4_yrem",   32'(bus.Remain), 32'd2);

    // Emergency pre-emption toward side 2
    do_reset();
    bus.Req     = 4'hF;
    bus.Density = 16'h0200;
    step();
    bus.Emerg_Req  = 1'b1;
    bus.Emerg_Side = 2'd2;
    step();
    check("s5_yellow", 32'(bus.Phase), 32'd1);
    repeat (2) step();
    check("s5_allred", 32'(bus.Phase), 32'd2);
    step();
    check("s5_side",   32'(bus.Side),   32'd2);
    check("s5_remain", 32'(bus.Remain), 32'd8);
    check("s5_ea",     32'(bus.Emerg_Active), 32'd1);
    repeat (3) step();
    check("s5_frozen", 32'(bus.Remain), 32'd8);
    bus.Emerg_Req = 1'b0;
    step();
    check("s5_resume", 32'(bus.Remain), 32'd7);
    check("s5_ea_off", 32'(bus.Emerg_Active), 32'd0);

    // Reset during yellow on side 3
    bus.Req = 4'b1000;
    wait_sc(40);
    check("s6_side3", 32'(bus.Side), 32'd3);
    bus.Req = 4'h0;
    wait_phase(1, 20);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check("s6_side",   32'(bus.Side),   32'd0);
    check("s6_phase",  32'(bus.Phase),  32'd0);
    check("s6_remain", 32'(bus.Remain), 32'd4);
    check("s6_sc",     32'(bus.Side_Change), 32'd0);
    @(posedge Clk);
    #1;
    check_all("s6_hold");
    Reset = 1'b0;

    // No tick: input changes have no effect
    bus.Tick    = 1'b0;
    bus.Req     = 4'h0;
    bus.Density = 16'hFFFF;
    repeat (5) step();
    check("s6_tick0_remain", 32'(bus.Remain), 32'd4);
    check("s6_tick0_phase",  32'(bus.Phase),  32'd0);
    bus.Tick = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.Tick    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus.Req = 4'($urandom);
      bus.Density = 16'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        bus.Emerg_Req  = ~bus.Emerg_Req;
        bus.Emerg_Side = 2'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
